decode_stage: RTL and testbench

Registered, parametrised instruction-decode pipeline stage with valid/ready handshakes on both sides. It splits each fetched instruction word into opcode, register addresses, flags and immediate, and holds the decoded fields in an output register for the ALU/issue stage. It adds register-indirect extended opcodes: the opcode low field is read from the register file via a one-cycle read port. It sits between fetch and ALU issue.

---
 rtl/decode_stage.sv | 192 +++++++++++++++++++
 tb/tb_decode_stage.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Registered instruction-decode stage between fetch and ALU issue.
// Extended opcodes take their low half from a register-file read issued in the accept cycle.
module decode_stage #(
  parameter int WORD_W     = 32,
  parameter int OP_W       = 4,
  parameter int REG_AW     = 4,
  parameter int IMM_W      = 16,
  parameter int EXT_THRESH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   in_inst,
  output logic                rf_re,
  output logic [REG_AW-1:0]   rf_raddr,
  input  logic [WORD_W-1:0]   rf_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*OP_W-1:0]   out_opcode,
  output logic [REG_AW-1:0]   out_rd,
  output logic [REG_AW-1:0]   out_rs,
  output logic                out_isfloat,
  output logic                out_src,
  output logic [1:0]          out_dst,
  output logic                out_iswrite,
  output logic [IMM_W-1:0]    out_imm,
  output logic                out_ext
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // out_* fields are held constant while out_valid && !out_ready.

  localparam int DST_LO  = IMM_W;
  localparam int SRC_BIT = IMM_W + 2;
  localparam int FLT_BIT = IMM_W + 3;
  localparam int RS_LO   = IMM_W + 4;
  localparam int RD_LO   = RS_LO + REG_AW;
  localparam int OPM_LO  = RD_LO + REG_AW;

  if (OP_W + 2 * REG_AW + 4 + IMM_W != WORD_W) begin : g_layout_err
    $error("decode_stage: OP_W + 2*REG_AW + 4 + IMM_W must equal WORD_W");
  end

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_EXT   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [OP_W-1:0]   op_msb_q, op_msb_d;
  logic [OP_W-1:0]   op_lsb_q, op_lsb_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic              isfloat_q, isfloat_d;
  logic              src_q, src_d;
  logic [1:0]        dst_q, dst_d;
  logic              iswrite_q, iswrite_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic              ext_q, ext_d;
  logic              valid_q, valid_d;

  logic [OP_W-1:0]   in_op_msb;
  logic [OP_W-1:0]   in_op_lsb;
  logic [REG_AW-1:0] in_rd;
  logic [REG_AW-1:0] in_rs;
  logic              in_isfloat;
  logic              in_src;
  logic [1:0]        in_dst;
  logic [IMM_W-1:0]  in_imm;
  logic              in_is_ext;
  logic              accept;
  logic              ext_accept;
  logic              unused_rdata;

  assign in_op_msb  = in_inst[OPM_LO +: OP_W];
  assign in_rd      = in_inst[RD_LO +: REG_AW];
  assign in_rs      = in_inst[RS_LO +: REG_AW];
  assign in_isfloat = in_inst[FLT_BIT];
  assign in_src     = in_inst[SRC_BIT];
  assign in_dst     = in_inst[DST_LO +: 2];
  assign in_imm     = in_inst[IMM_W-1:0];
  assign in_op_lsb  = in_inst[IMM_W-1 -: OP_W];
  assign in_is_ext  = (int'(in_op_msb) > EXT_THRESH) && in_src;

  // Only the low opcode half of the read data is meaningful.
  assign unused_rdata = ^rf_rdata[WORD_W-1:OP_W];

  always_comb begin
    in_ready = 1'b0;
    if (rst_n && !flush) begin
      in_ready = (state_q == ST_EMPTY) || ((state_q == ST_FULL) && out_ready);
    end
  end

  assign accept     = in_valid && in_ready;
  assign ext_accept = accept && in_is_ext;
  assign rf_re      = ext_accept;
  assign rf_raddr   = ext_accept ? in_rs : '0;

  always_comb begin
    state_d   = state_q;
    op_msb_d  = op_msb_q;
    op_lsb_d  = op_lsb_q;
    rd_d      = rd_q;
    rs_d      = rs_q;
    isfloat_d = isfloat_q;
    src_d     = src_q;
    dst_d     = dst_q;
    iswrite_d = iswrite_q;
    imm_d     = imm_q;
    ext_d     = ext_q;

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EXT: begin
          op_lsb_d = rf_rdata[OP_W-1:0];
          ext_d    = 1'b1;
          state_d  = ST_FULL;
        end
        ST_EMPTY, ST_FULL: begin
          if (accept) begin
            // Fields are captured for ext instructions too; only op_lsb is patched later.
            op_msb_d  = in_op_msb;
            op_lsb_d  = in_op_lsb;
            rd_d      = in_rd;
            rs_d      = in_rs;
            isfloat_d = in_isfloat;
            src_d     = in_src;
            dst_d     = in_dst;
            iswrite_d = &in_dst;
            imm_d     = in_imm;
            ext_d     = 1'b0;
            state_d   = in_is_ext ? ST_EXT : ST_FULL;
          end else if (state_q == ST_FULL && out_ready) begin
            state_d = ST_EMPTY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    valid_d = (state_d == ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      valid_q   <= 1'b0;
      op_msb_q  <= '0;
      op_lsb_q  <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      isfloat_q <= 1'b0;
      src_q     <= 1'b0;
      dst_q     <= '0;
      iswrite_q <= 1'b0;
      imm_q     <= '0;
      ext_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      op_msb_q  <= op_msb_d;
      op_lsb_q  <= op_lsb_d;
      rd_q      <= rd_d;
      rs_q      <= rs_d;
      isfloat_q <= isfloat_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      iswrite_q <= iswrite_d;
      imm_q     <= imm_d;
      ext_q     <= ext_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_opcode  = {op_msb_q, op_lsb_q};
  assign out_rd      = rd_q;
  assign out_rs      = rs_q;
  assign out_isfloat = isfloat_q;
  assign out_src     = src_q;
  assign out_dst     = dst_q;
  assign out_iswrite = iswrite_q;
  assign out_imm     = imm_q;
  assign out_ext     = ext_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: reference model feeds an expected queue, a monitor checks every output transfer.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic        rf_re;
  logic [3:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_opcode;
  logic [3:0]  out_rd;
  logic [3:0]  out_rs;
  logic        out_isfloat;
  logic        out_src;
  logic [1:0]  out_dst;
  logic        out_iswrite;
  logic [15:0] out_imm;
  logic        out_ext;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .rf_re(rf_re), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_rd(out_rd), .out_rs(out_rs), .out_isfloat(out_isfloat), .out_src(out_src),
    .out_dst(out_dst), .out_iswrite(out_iswrite), .out_imm(out_imm), .out_ext(out_ext)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic        isfloat;
    logic        src;
    logic [1:0]  dst;
    logic        iswrite;
    logic [15:0] imm;
    logic        ext;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rf[16];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        m_full;
  logic        m_ext;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit ref_is_ext(input logic [31:0] inst);
    int unsigned w;
    w = inst;
    return ((w >> 28) > 8) && (((w >> 18) % 2) == 1);
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] inst);
    exp_t e;
    int unsigned w, msb, lsb, rs, dst;
    w   = inst;
    msb = w >> 28;
    rs  = (w >> 20) % 16;
    dst = (w >> 16) % 4;
    lsb = ref_is_ext(inst) ? (rf[rs] % 16) : ((w >> 12) % 16);
    e.opcode  = 8'(msb * 16 + lsb);
    e.rd      = 4'((w >> 24) % 16);
    e.rs      = 4'(rs);
    e.isfloat = 1'((w >> 19) % 2);
    e.src     = 1'((w >> 18) % 2);
    e.dst     = 2'(dst);
    e.iswrite = (dst == 3);
    e.imm     = 16'(w % 65536);
    e.ext     = ref_is_ext(inst);
    return e;
  endfunction

  function automatic bit model_ready();
    return rst_n && !flush && ((!m_full && !m_ext) || (m_full && out_ready));
  endfunction

  // Register-file responder: one-cycle read, noise when not reading.
  always @(posedge clk) begin
    if (rf_re) rf_rdata <= rf[rf_raddr];
    else rf_rdata <= $urandom;
  end

  // Model of occupancy: m_full = a result is presented, m_ext = waiting for register data.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full = 1'b0;
      m_ext  = 1'b0;
      exp_q.delete();
    end else begin
      bit rdy;
      exp_t e;
      rdy = model_ready();
      if (flush) begin
        if (m_ext) void'(exp_q.pop_back());
        else if (m_full && !out_ready) void'(exp_q.pop_front());
        m_full = 1'b0;
        m_ext  = 1'b0;
      end else if (m_ext) begin
        m_ext  = 1'b0;
        m_full = 1'b1;
      end else if (in_valid && rdy) begin
        e = ref_decode(in_inst);
        exp_q.push_back(e);
        m_ext  = e.ext;
        m_full = !e.ext;
      end else if (m_full && out_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      bit   rdy, re;
      exp_t act, exp;
      rdy = model_ready();
      re  = in_valid && rdy && ref_is_ext(in_inst);
      check("out_valid", 64'(out_valid), 64'(m_full));
      check("in_ready", 64'(in_ready), 64'(rdy));
      check("rf_re", 64'(rf_re), 64'(re));
      check("rf_raddr", 64'(rf_raddr), re ? 64'((in_inst >> 20) % 16) : 64'd0);
      if (out_valid && out_ready) begin
        act = '{out_opcode, out_rd, out_rs, out_isfloat, out_src, out_dst,
                out_iswrite, out_imm, out_ext};
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(act), 64'd0);
        end else begin
          exp = exp_q.pop_front();
          check("decoded_fields", 64'(act), 64'(exp));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_one(input logic [31:0] inst, output logic re_seen, output logic [3:0] addr_seen);
    bit got;
    got = 0;
    re_seen = 1'b0;
    addr_seen = '0;
    in_inst  = inst;
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        re_seen = rf_re;
        addr_seen = rf_raddr;
        break;
      end
    end
    if (!got) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_inst  = $urandom;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic       re_s;
  logic [3:0] ad_s;

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    rf[3] = 32'h0000_0007;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_inst = 32'h9A34_0000;
    #23;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_rf_re", 64'(rf_re), 64'd0);
    check("reset_opcode", 64'(out_opcode), 64'd0);
    in_valid = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;

    // Plain decode
    drive_one(32'h3120_1234, re_s, ad_s);
    @(negedge clk);
    check("plain_opcode", 64'(out_opcode), 64'h31);
    check("plain_rd_rs", 64'({out_rd, out_rs}), 64'h12);
    check("plain_flags", 64'({out_isfloat, out_src, out_dst, out_iswrite, out_ext}), 64'd0);
    check("plain_imm", 64'(out_imm), 64'h1234);

    // Write decode
    @(posedge clk); #1;
    drive_one(32'h1203_5000, re_s, ad_s);
    @(negedge clk);
    check("write_opcode", 64'(out_opcode), 64'h15);
    check("write_dst_iswrite", 64'({out_dst, out_iswrite}), 64'b111);
    check("write_imm", 64'(out_imm), 64'h5000);

    // Extended opcode via register file
    @(posedge clk); #1;
    drive_one(32'h9A34_0000, re_s, ad_s);
    check("ext_rf_re", 64'(re_s), 64'd1);
    check("ext_rf_raddr", 64'(ad_s), 64'd3);
    @(negedge clk);
    check("ext_in_ready_low", 64'(in_ready), 64'd0);
    check("ext_out_valid_low", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ext_opcode", 64'(out_opcode), 64'h97);
    check("ext_rd_src_ext", 64'({out_rd, out_src, out_ext}), 64'({4'hA, 1'b1, 1'b1}));

    // Threshold boundary: op_msb == 8 is not extended
    @(posedge clk); #1;
    drive_one(32'h8A34_0000, re_s, ad_s);
    check("bound_rf_re", 64'(re_s), 64'd0);
    @(negedge clk);
    check("bound_opcode", 64'(out_opcode), 64'h80);
    check("bound_ext", 64'(out_ext), 64'd0);

    // Backpressure: result must hold for 5 cycles
    wait_cycles(2);
    out_ready = 1'b0;
    drive_one(32'h1203_5000, re_s, ad_s);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_fields", 64'({out_opcode, out_imm, out_iswrite}), 64'({8'h15, 16'h5000, 1'b1}));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;

    // Stream 4 plain instructions back to back
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_inst  = {4'(i + 1), 4'(i), 4'(i + 2), 4'h0, 16'(16'h1000 * i + 16'h0abc)};
      @(negedge clk);
      check("stream_in_ready", 64'(in_ready), 64'd1);
      if (i > 0) check("stream_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_last_valid", 64'(out_valid), 64'd1);
    check("stream_last_imm", 64'(out_imm), 64'h3abc);
    wait_cycles(2);

    // Flush during EXT discards the pending result
    drive_one(32'hC556_0000, re_s, ad_s);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_no_output", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    drive_one(32'h3120_1234, re_s, ad_s);
    @(negedge clk);
    check("post_flush_opcode", 64'(out_opcode), 64'h31);
    wait_cycles(2);

    // Reset asserted while in EXT
    drive_one(32'hF7B4_0000, re_s, ad_s);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_ext_out_valid", 64'(out_valid), 64'd0);
    check("rst_ext_in_ready", 64'(in_ready), 64'd0);
    check("rst_ext_rf_re", 64'(rf_re), 64'd0);
    check("rst_ext_fields", 64'({out_opcode, out_rd, out_ext}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_inst   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    wait_cycles(6);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
